// File: rtl/freq_meter.sv
// Square-wave meter: reports high time, low time, period and divider setting
// of an asynchronous input, measured in clk cycles, with a stuck-input watchdog.
module freq_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] low_time,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] divisor_est,
  output logic             valid,
  output logic             stuck
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt_high;
  logic [WIDTH-1:0] r_cnt_low;
  logic [WIDTH-1:0] w_cnt_high_nxt;
  logic [WIDTH-1:0] w_cnt_low_nxt;
  logic [WD_W-1:0]  r_wd;
  logic [WIDTH:0]   w_sum;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_timeout;
  logic             w_publish;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_edge    = w_rise | w_fall;
  // An edge in the expiry cycle clears the watchdog instead of tripping it
  assign w_timeout = ~w_edge && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_sum     = {1'b0, r_cnt_high} + {1'b0, r_cnt_low};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_high_nxt = r_cnt_high;
    w_cnt_low_nxt  = r_cnt_low;
    w_publish      = 1'b0;
    case (r_state)
      WAIT_LOW: begin
        if (!r_s2) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_cnt_high_nxt = WIDTH'(1);
          w_cnt_low_nxt  = '0;
          w_state_nxt    = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (w_fall) begin
          w_cnt_low_nxt = WIDTH'(1);
          w_state_nxt   = MEAS_LOW;
        end else if (r_cnt_high != CNT_MAX) begin
          w_cnt_high_nxt = r_cnt_high + WIDTH'(1);
        end
      end
      MEAS_LOW: begin
        if (w_rise) begin
          w_publish      = 1'b1;
          w_cnt_high_nxt = WIDTH'(1);
          w_cnt_low_nxt  = '0;
          w_state_nxt    = MEAS_HIGH;
        end else if (r_cnt_low != CNT_MAX) begin
          w_cnt_low_nxt = r_cnt_low + WIDTH'(1);
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
    if (w_timeout) w_state_nxt = WAIT_LOW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_LOW;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt_high  <= '0;
      r_cnt_low   <= '0;
      r_wd        <= '0;
      high_time   <= '0;
      low_time    <= '0;
      period      <= '0;
      divisor_est <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      r_s1       <= sig_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_state    <= w_state_nxt;
      r_cnt_high <= w_cnt_high_nxt;
      r_cnt_low  <= w_cnt_low_nxt;
      if (w_edge) begin
        r_wd <= '0;
      end else if (r_wd != '1) begin
        r_wd <= r_wd + WD_W'(1);
      end
      valid <= w_publish;
      if (w_publish) begin
        high_time   <= r_cnt_high;
        low_time    <= r_cnt_low;
        period      <= w_sum[WIDTH] ? CNT_MAX : w_sum[WIDTH-1:0];
        divisor_est <= r_cnt_high - WIDTH'(1);
        stuck       <= 1'b0;
      end else if (w_timeout) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: expected results are queued when a period
// is closed by the stimulus and compared, with arrival cycle, on each valid.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_a;
  logic        sig_b;
  logic [31:0] high_a, low_a, per_a, div_a;
  logic        valid_a, stuck_a;
  logic [3:0]  high_b, low_b, per_b, div_b;
  logic        valid_b, stuck_b;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] p;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   prev_h = 0;
  int   prev_l = 0;
  bit   armed = 0;

  freq_meter #(.WIDTH(32), .TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .sig_in(sig_a),
    .high_time(high_a), .low_time(low_a), .period(per_a), .divisor_est(div_a),
    .valid(valid_a), .stuck(stuck_a)
  );

  freq_meter #(.WIDTH(4), .TIMEOUT(64)) u_sat (
    .clk(clk), .reset(reset), .sig_in(sig_b),
    .high_time(high_b), .low_time(low_b), .period(per_b), .divisor_est(div_b),
    .valid(valid_b), .stuck(stuck_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (valid_a) begin
      nvec++;
      assert (sb.size() > 0) else begin
        nerr++;
        $error("FAIL unexpected_valid observed=valid@%0d expected=no valid", cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("high_time", high_a, e.h);
        check("low_time", low_a, e.l);
        check("period", per_a, e.p);
        check("divisor_est", div_a, e.d);
        check("stuck_at_valid", {31'b0, stuck_a}, 32'd0);
      end
    end
  end

  task automatic push_prev();
    if (armed) begin
      sb.push_back('{h: prev_h, l: prev_l, p: prev_h + prev_l, d: prev_h - 1, cyc: cyc + 3});
    end
  endtask

  task automatic drive_period(input int h, input int l);
    push_prev();
    sig_a = 1'b1;
    repeat (h) @(negedge clk);
    sig_a = 1'b0;
    repeat (l) @(negedge clk);
    prev_h = h;
    prev_l = l;
    armed  = 1;
  endtask

  task automatic drive_low(input int n);
    sig_a = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic close_hold();
    push_prev();
    sig_a = 1'b1;
    armed = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"}, high_a, 32'd0);
    check({tag, "_low"}, low_a, 32'd0);
    check({tag, "_period"}, per_a, 32'd0);
    check({tag, "_div"}, div_a, 32'd0);
    check({tag, "_valid"}, {31'b0, valid_a}, 32'd0);
    check({tag, "_stuck"}, {31'b0, stuck_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=still running expected=finished");
    $fatal(1, "time limit exceeded");
  end

  initial begin
    int n;
    int tgt;
    bit found;
    reset = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    drive_low(3);

    // 4/4 symmetric
    repeat (3) drive_period(4, 4);
    // 3/7 asymmetric, then a mixed 3/10 period, then 10/10
    repeat (3) drive_period(3, 7);
    drive_period(3, 10);
    repeat (3) drive_period(10, 10);

    // Hold high: watchdog trips 16 cycles after the last published edge
    n = cyc;
    close_hold();
    while (cyc < n + 18) @(negedge clk);
    check("stuck_before_expiry", {31'b0, stuck_a}, 32'd0);
    @(negedge clk);
    check("stuck_at_expiry", {31'b0, stuck_a}, 32'd1);
    check("hold_high", high_a, 32'd10);
    check("hold_low", low_a, 32'd10);
    check("hold_period", per_a, 32'd20);
    check("hold_div", div_a, 32'd9);
    repeat (20) @(negedge clk);
    check("stuck_level", {31'b0, stuck_a}, 32'd1);

    // Resume 5/5; stuck persists until the next valid
    drive_low(5);
    drive_period(5, 5);
    check("stuck_until_valid", {31'b0, stuck_a}, 32'd1);
    repeat (2) drive_period(5, 5);

    // Reset in the middle of the low phase discards the period
    drive_period(6, 3);
    drive_low(2);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    armed = 0;
    drive_low(3);
    repeat (2) drive_period(4, 4);

    // Minimum period: toggle every cycle
    repeat (6) drive_period(1, 1);
    close_hold();
    repeat (8) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    // Saturation on the narrow instance: 20 high, 2 low
    repeat (80) @(negedge clk);
    sig_b = 1'b1;
    repeat (20) @(negedge clk);
    sig_b = 1'b0;
    repeat (2) @(negedge clk);
    tgt = cyc + 3;
    sig_b = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (valid_b) found = 1;
    end
    check("sat_valid_cycle", found ? cyc : -1, tgt);
    check("sat_high", {28'b0, high_b}, 32'd15);
    check("sat_low", {28'b0, low_b}, 32'd2);
    check("sat_period", {28'b0, per_b}, 32'd15);
    check("sat_div", {28'b0, div_b}, 32'd14);
    check("sat_stuck", {31'b0, stuck_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
